update_dispatcher: RTL and testbench

UPDATE_DISPATCHER -- requirements
Module: update_dispatcher

---
 rtl/update_dispatcher.sv | 164 ++++++++++++++++
 tb/tb_update_dispatcher.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/update_dispatcher.sv
// rtl/update_dispatcher.sv - queues edge updates and hands them one at a time to a graph container
//
// Purpose: an update FIFO (DEPTH entries of {src,dst,e}) feeding a small
// dispatch FSM. Each update is popped into the u_* registers and then
// announced with a one-cycle container_reset pulse. The FSM waits for
// container_done before taking the next entry.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   in_valid/in_ready               push handshake for one update
//   in_src, in_dst, in_e            update fields (in_e passed through untouched)
//   container_reset                 one-cycle start pulse to the container
//   u_src, u_dst, u_e               update presented to the container
//   container_done                  level from the container, stale until the next start
//   busy                            an update is in flight
//   level                           FIFO occupancy
//   update_count                    completed updates, wraps at 16 bits
//   timeout                         sticky watchdog flag (WATCHDOG_EN builds only)
//
// Build option: define WATCHDOG_EN to add a 16-bit WAIT_DONE watchdog and the
// timeout output.

`ifndef PRED_WIDTH
`define PRED_WIDTH 15
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif

module update_dispatcher #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [`PRED_WIDTH:0]     in_src,
  input  logic [`PRED_WIDTH:0]     in_dst,
  input  logic [`WEIGHT_WIDTH:0]   in_e,
  output logic                     container_reset,
  output logic [`PRED_WIDTH:0]     u_src,
  output logic [`PRED_WIDTH:0]     u_dst,
  output logic [`WEIGHT_WIDTH:0]   u_e,
  input  logic                     container_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              update_count
`ifdef WATCHDOG_EN
  ,
  output logic                     timeout
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = `PRED_WIDTH + 1;
  localparam int WW = `WEIGHT_WIDTH + 1;

  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] src_mem [DEPTH];
  logic [PW-1:0] dst_mem [DEPTH];
  logic [WW-1:0] e_mem   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_ready        = (level != LVL_FULL);
  assign push            = in_valid && in_ready;
  // LOAD is only entered with level != 0, so the pop never underflows.
  assign pop             = (state == S_LOAD);
  assign busy            = (state != S_IDLE);
  assign container_reset = (state == S_START);

  // Storage needs no reset; only the pointers and occupancy define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr] <= in_src;
      dst_mem[wr_ptr] <= in_dst;
      e_mem[wr_ptr]   <= in_e;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        level <= level + LVL_ONE;
      else if (pop && !push)
        level <= level - LVL_ONE;
    end
  end

`ifdef WATCHDOG_EN
  logic [15:0] wd_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      u_src        <= '0;
      u_dst        <= '0;
      u_e          <= '0;
      update_count <= '0;
`ifdef WATCHDOG_EN
      wd_cnt       <= '0;
      timeout      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (level != '0) state <= S_LOAD;
        end
        S_LOAD: begin
          u_src <= src_mem[rd_ptr];
          u_dst <= dst_mem[rd_ptr];
          u_e   <= e_mem[rd_ptr];
          state <= S_START;
        end
        S_START: begin
          state <= S_SETTLE;
        end
        // container_done here still reflects the previous update, so it is
        // deliberately not looked at.
        S_SETTLE: begin
          state <= S_WAIT;
`ifdef WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (container_done) begin
            state        <= S_IDLE;
            update_count <= update_count + 16'd1;
          end
`ifdef WATCHDOG_EN
          else if (wd_cnt == 16'hFFFF) begin
            state   <= S_IDLE;
            timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_update_dispatcher.sv
// tb/tb_update_dispatcher.sv - randomized self-checking bench for update_dispatcher
//
// Purpose: drives pushes, models the container (start pulse -> done level,
// optionally stale or stalled) and compares dispatch order, timing rules,
// counters and reset behaviour against a queue-based reference.
//
// Ports: none (top-level bench). Define WATCHDOG_EN to also exercise timeout.

`ifndef PRED_WIDTH
`define PRED_WIDTH 15
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif

module tb_update_dispatcher;

  localparam int DEPTH = 8;
  localparam int PW    = `PRED_WIDTH + 1;
  localparam int WW    = `WEIGHT_WIDTH + 1;

  typedef struct packed {
    logic [PW-1:0] s;
    logic [PW-1:0] d;
    logic [WW-1:0] e;
  } upd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [PW-1:0] in_src = '0;
  logic [PW-1:0] in_dst = '0;
  logic [WW-1:0] in_e = '0;
  logic container_done = 1'b0;
  logic in_ready;
  logic container_reset;
  logic [PW-1:0] u_src;
  logic [PW-1:0] u_dst;
  logic [WW-1:0] u_e;
  logic busy;
  logic [$clog2(DEPTH):0] level;
  logic [15:0] update_count;
`ifdef WATCHDOG_EN
  logic timeout;
`endif

  update_dispatcher #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_src(in_src),
    .in_dst(in_dst),
    .in_e(in_e),
    .container_reset(container_reset),
    .u_src(u_src),
    .u_dst(u_dst),
    .u_e(u_e),
    .container_done(container_done),
    .busy(busy),
    .level(level),
    .update_count(update_count)
`ifdef WATCHDOG_EN
    ,
    .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  upd_t q[$];          // accepted updates not yet announced
  int   ph = 0;        // container model phase
  int   cd = 0;        // cycles until done rises
  int   mode_d = 0;    // -1: finish immediately, else delay
  bit   rnd_d = 0;
  bit   stall = 0;
  int   exp_cnt = 0;
  int   pulses = 0;
  int   cyc = 0;
  int   last_pulse = -100;
  int   last_gap = 0;
  upd_t prev_u = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) q.push_back({in_src, in_dst, in_e});
  end

  // Container model and protocol monitor.
  always @(negedge clk) begin
    upd_t cur;
    int dd;
    cur = {u_src, u_dst, u_e};
    cyc++;
    if (reset) begin
      ph = 0;
      container_done = 1'b0;
    end else begin
      check("u_stable", (cur == prev_u) || container_reset, 1);
      case (ph)
        1: begin   // SETTLE cycle: leave any old done high across the edge
          check("settle_busy", busy, 1);
          dd = rnd_d ? int'($urandom_range(0, 5)) - 1 : mode_d;
          if (dd < 0 && !stall) begin
            container_done = 1'b1;
            ph = 4;
          end else begin
            cd = dd < 0 ? 0 : dd;
            ph = 5;
          end
        end
        5: begin   // first WAIT cycle: stale done must not have completed it
          check("stale_ignored", busy, 1);
          container_done = 1'b0;
          ph = 2;
        end
        4: begin
          check("wait_busy", busy, 1);
          ph = 3;
        end
        2: begin
          if (!stall) begin
            check("early_done", busy, 1);
            if (cd == 0) begin
              container_done = 1'b1;
              ph = 3;
            end else cd--;
          end
        end
        3: begin
          exp_cnt++;
          check("done_idle", busy, 0);
          check("update_count", update_count, exp_cnt);
          ph = 0;
        end
        default: ;
      endcase
      if (container_reset) begin
        pulses++;
        last_gap = cyc - last_pulse;
        last_pulse = cyc;
        check("pulse_phase", ph, 0);
        check("pulse_gap_ok", last_gap >= 5, 1);
        check("queue_nonempty", q.size() != 0, 1);
        if (q.size() != 0) check("dispatch", cur, q.pop_front());
        ph = 1;
      end
    end
    prev_u = cur;
  end

  task automatic push(input logic [PW-1:0] s, input logic [PW-1:0] d, input logic [WW-1:0] e);
    int n;
    n = 0;
    in_src = s;
    in_dst = d;
    in_e = e;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("push_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (!(q.size() == 0 && ph == 0 && !busy && level == 0) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_in_time", n < max, 1);
    check("drain_count", update_count, exp_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    stall = 0;
    repeat (2) begin @(posedge clk); #1; end
    q.delete();
    exp_cnt = 0;
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse", container_reset, 0);
    check("rst_count", update_count, 0);
    check("rst_u", {u_src, u_dst, u_e}, 0);
    check("rst_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Latency: push on edge N -> pulse during cycle N+2.
    mode_d = 2;
    push(3, 5, 16'h0010);
    @(negedge clk); check("lat_n0", container_reset, 0);
    @(negedge clk); check("lat_n1", container_reset, 0);
    @(negedge clk); check("lat_n2", container_reset, 1);
    check("lat_u", {u_src, u_dst, u_e}, {16'd3, 16'd5, 16'h0010});
    @(posedge clk); #1;
    drain(100);
    check("lat_u_held", {u_src, u_dst, u_e}, {16'd3, 16'd5, 16'h0010});

    // Back-to-back with an instantly finishing container: 5-cycle spacing.
    mode_d = -1;
    push(1, 2, 16'hFFFF);
    push(4, 6, 16'h8000);
    push(7, 9, 16'h0001);
    drain(200);
    check("b2b_gap", last_gap, 5);
    check("b2b_count", update_count, 4);

    // Three updates with a slower container.
    mode_d = 3;
    for (int i = 0; i < 3; i++) push(PW'(10 + i), PW'(20 + i), WW'(i * 7));
    drain(200);
    check("slow_count", update_count, 7);
    check("slow_level", level, 0);

    // Stalled container: fill the FIFO and hold one more push pending.
    stall = 1;
    mode_d = 1;
    p0 = pulses;
    for (int i = 0; i < DEPTH + 1; i++) push(PW'(100 + i), PW'(200 + i), WW'(300 + i));
    in_src = 16'd109; in_dst = 16'd209; in_e = 16'd309; in_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("full_level", level, DEPTH);
    check("full_ready", in_ready, 0);
    check("full_busy", busy, 1);
    stall = 0;
    begin
      int n;
      n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      check("full_resume", in_ready, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain(500);
    check("full_pulses", pulses - p0, DEPTH + 2);

    // Reset in WAIT_DONE with four entries queued.
    stall = 1;
    for (int i = 0; i < 5; i++) push(PW'(50 + i), PW'(60 + i), WW'(70 + i));
    repeat (6) begin @(posedge clk); #1; end
    check("pre_rst_level", level, 4);
    do_reset();
    check("mid_rst_level", level, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_u", {u_src, u_dst, u_e}, 0);
    check("mid_rst_count", update_count, 0);
    check("mid_rst_ready", in_ready, 1);
    p0 = pulses;
    repeat (20) begin @(posedge clk); #1; end
    check("mid_rst_no_pulse", pulses, p0);

    // Randomized traffic with random container delays.
    rnd_d = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
      push(PW'($urandom), PW'($urandom), WW'($urandom));
    end
    drain(3000);
    check("rnd_count", update_count, 40);
    rnd_d = 0;

`ifdef WATCHDOG_EN
    stall = 1;
    mode_d = 0;
    push(11, 12, 13);
    push(14, 15, 16);
    begin
      int n;
      n = 0;
      while (!timeout && n < 70000) begin @(posedge clk); #1; n++; end
      check("wd_timeout", timeout, 1);
    end
    check("wd_count", update_count, exp_cnt);
    ph = 0;
    stall = 0;
    drain(200);
    check("wd_next", update_count, 41);
    check("wd_sticky", timeout, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
